// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: parameter defaults,
// FSM state encoding and the redirect-source selector.
package pc_seq_pkg;

  localparam int PC_W_DEFAULT      = 12;
  localparam int RAS_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_BR,
    SRC_RET,
    SRC_CALL,
    SRC_JMP
  } redir_src_t;

  // Fixed priority: EX-stage branch beats the ID-stage sources, and among those
  // ret > call > jmp. Losers are dropped entirely, including their stack effect.
  function automatic redir_src_t pick_source(input logic br, input logic rt,
                                             input logic cl, input logic jp);
    redir_src_t src;
    if (br)      src = SRC_BR;
    else if (rt) src = SRC_RET;
    else if (cl) src = SRC_CALL;
    else if (jp) src = SRC_JMP;
    else         src = SRC_NONE;
    return src;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack kept as a circular buffer: a push into a full stack
// silently overwrites the oldest entry, so recent call depth is preserved.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_ptr;

  // Top of stack sits one slot behind the write pointer, wrapping at DEPTH.
  always_comb begin
    w_top_ptr = (r_wr_ptr == '0) ? LAST_PTR : r_wr_ptr - PTR_W'(1);
    top       = r_mem[w_top_ptr];
    empty     = (r_count == '0);
    full      = (r_count == FULL_CNT);
  end

  // Entry storage carries no reset; stale contents are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; a push when full keeps the count saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (push) begin
      r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (!full) r_count <= r_count + CNT_W'(1);
    end else if (pop && !empty) begin
      r_wr_ptr <= w_top_ptr;
      r_count  <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: pc register, RUN/FLUSH/HALT control FSM,
// redirect target mux and return-address stack bookkeeping.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEFAULT,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] id_target,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            flush,
  output logic            ras_ovf,
  output logic            ras_unf
);

  seq_state_t      r_state, w_state_next;
  redir_src_t      w_src;
  logic [PC_W-1:0] r_pc, w_pc_next, w_pc_inc, w_target, w_ras_top;
  logic            w_push, w_pop, w_ras_empty, w_ras_full;
  logic            r_ovf, r_unf, w_unf_next;

  ras_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (PC_W)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .pop      (w_pop),
    .push_data(w_pc_inc),
    .top      (w_ras_top),
    .empty    (w_ras_empty),
    .full     (w_ras_full)
  );

  // Select the highest-priority redirect and its target; an empty-stack ret falls back to RESET_PC.
  always_comb begin
    w_src    = pick_source(br_taken, ret, call, jmp);
    w_pc_inc = r_pc + PC_W'(1);
    case (w_src)
      SRC_BR:            w_target = br_target;
      SRC_RET:           w_target = w_ras_empty ? RESET_PC : w_ras_top;
      SRC_CALL, SRC_JMP: w_target = id_target;
      default:           w_target = r_pc;
    endcase
  end

  // Next-state, next-pc and stack control; redirects are only honoured in RUN.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_unf_next   = 1'b0;
    fetch_valid  = 1'b0;
    flush        = 1'b0;
    case (r_state)
      RUN: begin
        fetch_valid = 1'b1;
        if (w_src != SRC_NONE) begin
          w_pc_next    = w_target;
          w_state_next = FLUSH;
          w_push       = (w_src == SRC_CALL);
          w_pop        = (w_src == SRC_RET) && !w_ras_empty;
          w_unf_next   = (w_src == SRC_RET) && w_ras_empty;
        end else if (halt) begin
          w_state_next = HALT;
        end else if (!stall) begin
          w_pc_next = w_pc_inc;
        end
      end
      FLUSH: begin
        flush        = 1'b1;
        w_state_next = RUN;
      end
      HALT: begin
        if (resume) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  // State, pc and status flags; overflow stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_unf   <= w_unf_next;
      if (w_push && w_ras_full) r_ovf <= 1'b1;
    end
  end

  assign pc      = r_pc;
  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: each scenario queues per-cycle
// stimulus with the expected post-edge outputs, then replays and compares.
module tb_pc_sequencer;

  typedef struct packed {
    logic        rst, stall, halt, resume, br;
    logic [11:0] brt;
    logic        jmp, call, ret;
    logic [11:0] idt;
  } stim_t;

  typedef struct packed {
    logic [11:0] pc;
    logic        fv, fl, ovf, unf;
  } exp_t;

  localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;

  logic        clk, rst, stall, halt, resume, br_taken, jmp, call, ret;
  logic [11:0] br_target, id_target, pc;
  logic        fetch_valid, flush, ras_ovf, ras_unf;

  int    total = 0;
  int    bad   = 0;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .call(call),
    .ret(ret), .id_target(id_target), .pc(pc), .fetch_valid(fetch_valid),
    .flush(flush), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(input logic [11:0] p, input int mode, input logic o, input logic u);
    exp_t e;
    e.pc = p; e.fv = (mode == M_RUN); e.fl = (mode == M_FLUSH); e.ovf = o; e.unf = u;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.pc = pc; e.fv = fetch_valid; e.fl = flush; e.ovf = ras_ovf; e.unf = ras_unf;
    return e;
  endfunction

  function automatic stim_t s_idle();
    stim_t s;
    s = '0;
    return s;
  endfunction
  function automatic stim_t s_rst();
    stim_t s; s = '0; s.rst = 1'b1; return s;
  endfunction
  function automatic stim_t s_stall();
    stim_t s; s = '0; s.stall = 1'b1; return s;
  endfunction
  function automatic stim_t s_halt();
    stim_t s; s = '0; s.halt = 1'b1; return s;
  endfunction
  function automatic stim_t s_br(input logic [11:0] t);
    stim_t s; s = '0; s.br = 1'b1; s.brt = t; return s;
  endfunction
  function automatic stim_t s_call(input logic [11:0] t);
    stim_t s; s = '0; s.call = 1'b1; s.idt = t; return s;
  endfunction
  function automatic stim_t s_ret();
    stim_t s; s = '0; s.ret = 1'b1; return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; stall = s.stall; halt = s.halt; resume = s.resume;
    br_taken = s.br; br_target = s.brt; jmp = s.jmp; call = s.call;
    ret = s.ret; id_target = s.idt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched(input stim_t s, input exp_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t got, want;
    sched(s_rst(), ex(12'h000, M_RUN, 1'b0, 1'b0));
    for (int i = 1; i <= 5; i++) sched(s_idle(), ex(12'(i), M_RUN, 1'b0, 1'b0));
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front()); tick(); want = exp_q.pop_front(); got = obs(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset[%0d] got pc=%h fv=%b fl=%b ovf=%b unf=%b want pc=%h fv=%b fl=%b ovf=%b unf=%b",
                 n, got.pc, got.fv, got.fl, got.ovf, got.unf, want.pc, want.fv, want.fl, want.ovf, want.unf);
      end else $display("reset[%0d] pc=%h ok", n, got.pc);
    end
  endtask

  task automatic test_branch();
    exp_t got, want;
    stim_t s;
    sched(s_br(12'h010), ex(12'h010, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(),      ex(12'h010, M_RUN,   1'b0, 1'b0));
    s = s_br(12'h200); s.jmp = 1'b1; s.idt = 12'h3AA; s.stall = 1'b1;
    sched(s,        ex(12'h200, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(), ex(12'h200, M_RUN,   1'b0, 1'b0));
    sched(s_idle(), ex(12'h201, M_RUN,   1'b0, 1'b0));
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front()); tick(); want = exp_q.pop_front(); got = obs(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL branch[%0d] got pc=%h fv=%b fl=%b ovf=%b unf=%b want pc=%h fv=%b fl=%b ovf=%b unf=%b",
                 n, got.pc, got.fv, got.fl, got.ovf, got.unf, want.pc, want.fv, want.fl, want.ovf, want.unf);
      end else $display("branch[%0d] pc=%h ok", n, got.pc);
    end
  endtask

  task automatic test_call_ret();
    exp_t got, want;
    sched(s_br(12'h020),   ex(12'h020, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(),        ex(12'h020, M_RUN,   1'b0, 1'b0));
    sched(s_call(12'h300), ex(12'h300, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(),        ex(12'h300, M_RUN,   1'b0, 1'b0));
    sched(s_idle(),        ex(12'h301, M_RUN,   1'b0, 1'b0));
    sched(s_ret(),         ex(12'h021, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(),        ex(12'h021, M_RUN,   1'b0, 1'b0));
    sched(s_idle(),        ex(12'h022, M_RUN,   1'b0, 1'b0));
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front()); tick(); want = exp_q.pop_front(); got = obs(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL call_ret[%0d] got pc=%h fv=%b fl=%b ovf=%b unf=%b want pc=%h fv=%b fl=%b ovf=%b unf=%b",
                 n, got.pc, got.fv, got.fl, got.ovf, got.unf, want.pc, want.fv, want.fl, want.ovf, want.unf);
      end else $display("call_ret[%0d] pc=%h ok", n, got.pc);
    end
  endtask

  task automatic test_ras_overflow();
    exp_t        got, want;
    logic [11:0] t;
    sched(s_br(12'h050), ex(12'h050, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(),      ex(12'h050, M_RUN,   1'b0, 1'b0));
    // Five nested calls to 0x100..0x500; the fifth lands on a full stack.
    for (int i = 1; i <= 5; i++) begin
      t = 12'(i * 256);
      sched(s_call(t), ex(t, M_FLUSH, (i == 5), 1'b0));
      sched(s_idle(),  ex(t, M_RUN,   (i == 5), 1'b0));
    end
    // Oldest return (0x051) was overwritten, so four rets come back, newest first.
    for (int i = 4; i >= 1; i--) begin
      t = 12'(i * 256 + 1);
      sched(s_ret(),  ex(t, M_FLUSH, 1'b1, 1'b0));
      sched(s_idle(), ex(t, M_RUN,   1'b1, 1'b0));
    end
    sched(s_ret(),  ex(12'h000, M_FLUSH, 1'b1, 1'b1));
    sched(s_idle(), ex(12'h000, M_RUN,   1'b1, 1'b0));
    sched(s_idle(), ex(12'h001, M_RUN,   1'b1, 1'b0));
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front()); tick(); want = exp_q.pop_front(); got = obs(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL ras_ovf[%0d] got pc=%h fv=%b fl=%b ovf=%b unf=%b want pc=%h fv=%b fl=%b ovf=%b unf=%b",
                 n, got.pc, got.fv, got.fl, got.ovf, got.unf, want.pc, want.fv, want.fl, want.ovf, want.unf);
      end else $display("ras_ovf[%0d] pc=%h ok", n, got.pc);
    end
  endtask

  task automatic test_wrap();
    exp_t got, want;
    sched(s_br(12'hFFE), ex(12'hFFE, M_FLUSH, 1'b1, 1'b0));
    sched(s_idle(),      ex(12'hFFE, M_RUN,   1'b1, 1'b0));
    sched(s_idle(),      ex(12'hFFF, M_RUN,   1'b1, 1'b0));
    for (int i = 0; i < 3; i++) sched(s_stall(), ex(12'hFFF, M_RUN, 1'b1, 1'b0));
    sched(s_idle(),      ex(12'h000, M_RUN,   1'b1, 1'b0));
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front()); tick(); want = exp_q.pop_front(); got = obs(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL wrap[%0d] got pc=%h fv=%b fl=%b ovf=%b unf=%b want pc=%h fv=%b fl=%b ovf=%b unf=%b",
                 n, got.pc, got.fv, got.fl, got.ovf, got.unf, want.pc, want.fv, want.fl, want.ovf, want.unf);
      end else $display("wrap[%0d] pc=%h ok", n, got.pc);
    end
  endtask

  task automatic test_halt_reset();
    exp_t  got, want;
    stim_t s;
    sched(s_idle(), ex(12'h001, M_RUN,  1'b1, 1'b0));
    sched(s_halt(), ex(12'h001, M_HALT, 1'b1, 1'b0));
    s = s_br(12'h123); s.halt = 1'b1;
    sched(s,        ex(12'h001, M_HALT, 1'b1, 1'b0));
    s = s_halt(); s.resume = 1'b1;
    sched(s,        ex(12'h001, M_RUN,  1'b1, 1'b0));
    sched(s_idle(), ex(12'h002, M_RUN,  1'b1, 1'b0));
    sched(s_halt(), ex(12'h002, M_HALT, 1'b1, 1'b0));
    s = s_rst(); s.halt = 1'b1;
    sched(s,        ex(12'h000, M_RUN,  1'b0, 1'b0));
    sched(s_idle(), ex(12'h001, M_RUN,  1'b0, 1'b0));
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front()); tick(); want = exp_q.pop_front(); got = obs(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL halt[%0d] got pc=%h fv=%b fl=%b ovf=%b unf=%b want pc=%h fv=%b fl=%b ovf=%b unf=%b",
                 n, got.pc, got.fv, got.fl, got.ovf, got.unf, want.pc, want.fv, want.fl, want.ovf, want.unf);
      end else $display("halt[%0d] pc=%h ok", n, got.pc);
    end
  endtask

  task automatic test_back_to_back();
    exp_t  got, want;
    stim_t s;
    s = s_br(12'h080); s.halt = 1'b1;                 // redirect beats halt
    sched(s,        ex(12'h080, M_FLUSH, 1'b0, 1'b0));
    s = s_br(12'h0F0); s.stall = 1'b1; s.halt = 1'b1; // all ignored in FLUSH
    sched(s,        ex(12'h080, M_RUN,   1'b0, 1'b0));
    s = s_call(12'h090); s.jmp = 1'b1;                // call beats jmp, pushes 0x081
    sched(s,        ex(12'h090, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(), ex(12'h090, M_RUN,   1'b0, 1'b0));
    s = s_ret(); s.call = 1'b1; s.idt = 12'h0C0;      // ret beats call, no push
    sched(s,        ex(12'h081, M_FLUSH, 1'b0, 1'b0));
    sched(s_idle(), ex(12'h081, M_RUN,   1'b0, 1'b0));
    sched(s_ret(),  ex(12'h000, M_FLUSH, 1'b0, 1'b1));
    sched(s_idle(), ex(12'h000, M_RUN,   1'b0, 1'b0));
    sched(s_stall(),ex(12'h000, M_RUN,   1'b0, 1'b0));
    s = s_stall(); s.jmp = 1'b1; s.idt = 12'h0D0;     // redirect beats stall
    sched(s,        ex(12'h0D0, M_FLUSH, 1'b0, 1'b0));
    sched(s_br(12'h0E0), ex(12'h0D0, M_RUN, 1'b0, 1'b0));
    sched(s_br(12'h0E0), ex(12'h0E0, M_FLUSH, 1'b0, 1'b0));
    sched(s_rst(),  ex(12'h000, M_RUN,   1'b0, 1'b0)); // reset abandons FLUSH
    sched(s_idle(), ex(12'h001, M_RUN,   1'b0, 1'b0));
    for (int n = 0; stim_q.size() > 0; n++) begin
      apply(stim_q.pop_front()); tick(); want = exp_q.pop_front(); got = obs(); total++;
      if (got !== want) begin
        bad++;
        $display("FAIL b2b[%0d] got pc=%h fv=%b fl=%b ovf=%b unf=%b want pc=%h fv=%b fl=%b ovf=%b unf=%b",
                 n, got.pc, got.fv, got.fl, got.ovf, got.unf, want.pc, want.fv, want.fl, want.ovf, want.unf);
      end else $display("b2b[%0d] pc=%h ok", n, got.pc);
    end
  endtask

  initial begin
    apply(s_rst());
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_wrap();
    test_halt_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
